// File: rtl/io_out_buffer.sv
// io_out_buffer
//   Byte-output buffer between the CPU memory-mapped I/O window and the
//   UART TX path / simulation host. CPU writes to offset 0 are queued in a
//   FIFO and drained over a valid/ready byte stream. A write to offset 4
//   requests program end: the FIFO drains, then sim_done latches.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   RUN   | normal operation, char writes are queued
//   DRAIN | halt requested, char writes ignored, waiting for FIFO empty
//   DONE  | all bytes drained, sim_done held until reset
//
// Ports
//   clk_in          single clock, rising edge
//   rst_in          synchronous reset, active low
//   io_wr           CPU I/O write strobe
//   io_addr [2:0]   offset in I/O page (0 = char out, 4 = halt)
//   io_data [7:0]   write data byte
//   io_buffer_full  back-pressure to CPU, raised with FULL_MARGIN free entries
//   tx_valid        FIFO head valid
//   tx_data [7:0]   FIFO head byte
//   tx_ready        consumer accepts head when tx_valid && tx_ready
//   overflow        sticky, a char write was dropped at true full
//   sim_done        sticky, halt requested and FIFO drained
//   done_code [7:0] data byte captured with the halt write
//   out_count[31:0] bytes accepted into the FIFO since reset

module io_out_buffer #(
    parameter int DEPTH_LOG2  = 4,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        io_wr,
    input  logic [2:0]  io_addr,
    input  logic [7:0]  io_data,
    output logic        io_buffer_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        overflow,
    output logic        sim_done,
    output logic [7:0]  done_code,
    output logic [31:0] out_count
);

    localparam int DEPTH = 2**DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   count;
    logic [PW-1:0]   free_cnt;
    logic [7:0]      mem [DEPTH];

    logic            empty;
    logic            full;
    logic            pop;
    logic            push;
    logic            drop;
    logic            capture;
    logic            char_wr;
    logic            halt_wr;

    // Extra pointer MSB distinguishes full from empty.
    assign empty    = (rd_ptr == wr_ptr);
    assign full     = (rd_ptr[PW-1] != wr_ptr[PW-1]) &&
                      (rd_ptr[PW-2:0] == wr_ptr[PW-2:0]);
    assign count    = wr_ptr - rd_ptr;
    assign free_cnt = PW'(DEPTH) - count;

    // Registered count only, so the flag leads the true full condition by
    // FULL_MARGIN entries and covers the CPU store latency.
    assign io_buffer_full = (free_cnt <= PW'(FULL_MARGIN));

    assign tx_valid = !empty && (state != ST_DONE);
    assign tx_data  = mem[rd_ptr[PW-2:0]];
    assign pop      = tx_valid && tx_ready;

    assign char_wr  = io_wr && (io_addr == 3'd0);
    assign halt_wr  = io_wr && (io_addr == 3'd4);

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        drop      = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_RUN: begin
                if (char_wr) begin
                    // A pop in the same cycle frees the slot the push needs.
                    if (!full || pop) begin
                        push = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end
                if (halt_wr) begin
                    capture   = 1'b1;
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (empty) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_DONE;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state     <= ST_RUN;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            overflow  <= 1'b0;
            sim_done  <= 1'b0;
            done_code <= 8'h00;
            out_count <= 32'd0;
        end else begin
            state <= state_nxt;
            if (push) begin
                wr_ptr    <= wr_ptr + PW'(1);
                out_count <= out_count + 32'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (capture) begin
                done_code <= io_data;
            end
            if (state_nxt == ST_DONE) begin
                sim_done <= 1'b1;
            end
        end
    end

    // Storage has no reset; the pointers alone define the contents.
    always_ff @(posedge clk_in) begin
        if (rst_in && push) begin
            mem[wr_ptr[PW-2:0]] <= io_data;
        end
    end

endmodule

// File: tb/tb_io_out_buffer.sv
module tb_io_out_buffer;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        io_wr;
    logic [2:0]  io_addr;
    logic [7:0]  io_data;
    logic        io_buffer_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        overflow;
    logic        sim_done;
    logic [7:0]  done_code;
    logic [31:0] out_count;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  sb [$];
    logic [31:0] exp_cnt;

    io_out_buffer #(.DEPTH_LOG2(4), .FULL_MARGIN(2)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .io_wr          (io_wr),
        .io_addr        (io_addr),
        .io_data        (io_data),
        .io_buffer_full (io_buffer_full),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .overflow       (overflow),
        .sim_done       (sim_done),
        .done_code      (done_code),
        .out_count      (out_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: inputs change at posedge+1, so the values seen at the
    // negedge are exactly those the next rising edge will act on.
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    always @(negedge clk_in) begin
        if (rst_in === 1'b1 && prev_valid && !prev_ready && tx_valid) begin
            chk("tx_data_stable", {24'd0, tx_data}, {24'd0, prev_data});
        end
        if (rst_in === 1'b1 && tx_valid && tx_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_tx_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
            end else begin
                chk("tx_byte_order", {24'd0, tx_data}, {24'd0, sb.pop_front()});
            end
        end
        prev_valid = tx_valid;
        prev_ready = tx_ready;
        prev_data  = tx_data;
    end

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d, input bit accept);
        io_wr   = 1'b1;
        io_addr = a;
        io_data = d;
        if (accept) begin
            sb.push_back(d);
            exp_cnt++;
        end
        cyc();
        io_wr = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_in = 1'b0;
        sb.delete();
        exp_cnt = 0;
        repeat (n) cyc();
        rst_in = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while ((sb.size() != 0 || tx_valid) && k < budget) begin
            cyc();
            k++;
        end
        chk(name, {31'd0, (sb.size() == 0 && !tx_valid)}, 32'd1);
    endtask

    initial begin
        rst_in   = 1'b0;
        io_wr    = 1'b0;
        io_addr  = 3'd0;
        io_data  = 8'h00;
        tx_ready = 1'b0;
        exp_cnt  = 0;

        // 1: reset held with io_wr active
        io_wr   = 1'b1;
        io_addr = 3'd0;
        io_data = 8'h5A;
        do_reset(3);
        io_wr = 1'b0;
        chk("rst_tx_valid",  {31'd0, tx_valid}, 32'd0);
        chk("rst_full",      {31'd0, io_buffer_full}, 32'd0);
        chk("rst_overflow",  {31'd0, overflow}, 32'd0);
        chk("rst_sim_done",  {31'd0, sim_done}, 32'd0);
        chk("rst_done_code", {24'd0, done_code}, 32'd0);
        chk("rst_out_count", out_count, 32'd0);

        // 2: "Hi" with consumer ready, one-cycle latency
        tx_ready = 1'b1;
        wr(3'd0, 8'h48, 1'b1);
        chk("hi_first_valid", {31'd0, tx_valid}, 32'd1);
        chk("hi_first_data",  {24'd0, tx_data}, 32'h48);
        wr(3'd0, 8'h69, 1'b1);
        chk("hi_second_data", {24'd0, tx_data}, 32'h69);
        cyc();
        chk("hi_drained", {31'd0, tx_valid}, 32'd0);
        chk("hi_out_count", out_count, 32'd2);

        // ignored offsets
        wr(3'd1, 8'h11, 1'b0);
        wr(3'd7, 8'h22, 1'b0);
        chk("bad_addr_count", out_count, 32'd2);
        chk("bad_addr_valid", {31'd0, tx_valid}, 32'd0);

        // 3: fill, early full flag, overflow drop, ordered drain
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr(3'd0, 8'(i), 1'b1);
            if (i == 12) chk("full_after_13", {31'd0, io_buffer_full}, 32'd0);
            if (i == 13) chk("full_after_14", {31'd0, io_buffer_full}, 32'd1);
        end
        chk("ovf_before_drop", {31'd0, overflow}, 32'd0);
        wr(3'd0, 8'hAA, 1'b0);
        chk("ovf_after_drop", {31'd0, overflow}, 32'd1);
        chk("ovf_out_count", out_count, 32'd18);
        tx_ready = 1'b1;
        wait_drain("fill_drain", 40);
        chk("full_clear", {31'd0, io_buffer_full}, 32'd0);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        // 4: simultaneous push/pop at full
        do_reset(1);
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) wr(3'd0, 8'(8'h80 + i), 1'b1);
        tx_ready = 1'b1;
        wr(3'd0, 8'h55, 1'b1);
        tx_ready = 1'b0;
        chk("pp_still_full", {31'd0, io_buffer_full}, 32'd1);
        chk("pp_overflow",   {31'd0, overflow}, 32'd0);
        chk("pp_out_count",  out_count, 32'd17);
        wr(3'd0, 8'hBB, 1'b0);
        chk("pp_truly_full_drop", {31'd0, overflow}, 32'd1);
        tx_ready = 1'b1;
        wait_drain("pp_drain", 40);

        // 5: halt with bytes pending, char writes ignored while draining
        do_reset(1);
        tx_ready = 1'b0;
        wr(3'd0, 8'h31, 1'b1);
        wr(3'd0, 8'h32, 1'b1);
        wr(3'd0, 8'h33, 1'b1);
        wr(3'd4, 8'h07, 1'b0);
        wr(3'd0, 8'h41, 1'b0);
        wr(3'd4, 8'h09, 1'b0);
        repeat (3) cyc();
        chk("halt_not_done", {31'd0, sim_done}, 32'd0);
        chk("halt_count", out_count, 32'd3);
        chk("halt_no_ovf", {31'd0, overflow}, 32'd0);
        tx_ready = 1'b1;
        begin
            int k = 0;
            while (!sim_done && k < 20) begin
                cyc();
                k++;
            end
        end
        chk("halt_sim_done", {31'd0, sim_done}, 32'd1);
        chk("halt_code", {24'd0, done_code}, 32'h07);
        chk("halt_sb_empty", sb.size(), 32'd0);
        wr(3'd4, 8'h99, 1'b0);
        wr(3'd0, 8'h42, 1'b0);
        chk("done_code_kept", {24'd0, done_code}, 32'h07);
        chk("done_count", out_count, 32'd3);
        chk("done_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("done_sticky", {31'd0, sim_done}, 32'd1);

        // 6: reset in DRAIN with 5 bytes buffered
        do_reset(1);
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(3'd0, 8'(8'h60 + i), 1'b1);
        wr(3'd4, 8'h3C, 1'b0);
        chk("drain_valid", {31'd0, tx_valid}, 32'd1);
        do_reset(1);
        chk("r6_tx_valid",  {31'd0, tx_valid}, 32'd0);
        chk("r6_sim_done",  {31'd0, sim_done}, 32'd0);
        chk("r6_done_code", {24'd0, done_code}, 32'd0);
        chk("r6_out_count", out_count, 32'd0);
        tx_ready = 1'b1;
        wr(3'd0, 8'h77, 1'b1);
        chk("r6_accept_valid", {31'd0, tx_valid}, 32'd1);
        chk("r6_accept_data",  {24'd0, tx_data}, 32'h77);
        chk("r6_accept_count", out_count, 32'd1);
        wait_drain("r6_drain", 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
